// File: rtl/phys_reg_file.sv
// Physical register file with per-register ready bits (scoreboard).
// Written by the Execute writeback port, busy-marked by Rename,
// read through two registered ports by Issue.
// Optional feature: define WB_BYPASS_EN to forward a same-cycle
// writeback onto a read port instead of returning the pre-edge value.
module phys_reg_file #(
  parameter int NUM_PREGS = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ex_valid,
  input  logic [31:0]                  i_ex_dst_val,
  input  logic [$clog2(NUM_PREGS)-1:0] i_ex_dst_index,
  input  logic                         i_alloc_valid,
  input  logic [$clog2(NUM_PREGS)-1:0] i_alloc_index,
  input  logic                         i_flush,
  input  logic                         i_rd0_en,
  input  logic [$clog2(NUM_PREGS)-1:0] i_rd0_index,
  output logic [31:0]                  o_rd0_val,
  output logic                         o_rd0_ready,
  input  logic                         i_rd1_en,
  input  logic [$clog2(NUM_PREGS)-1:0] i_rd1_index,
  output logic [31:0]                  o_rd1_val,
  output logic                         o_rd1_ready
);

  localparam int PW = $clog2(NUM_PREGS);

  logic [31:0]          r_regs [NUM_PREGS];
  logic [NUM_PREGS-1:0] r_ready;
  logic [31:0]          r_rd0Val;
  logic                 r_rd0Ready;
  logic [31:0]          r_rd1Val;
  logic                 r_rd1Ready;

  logic                 w_wbHit;
  logic                 w_allocHit;
  logic [NUM_PREGS-1:0] w_readyNext;
  logic [31:0]          w_rd0Val;
  logic                 w_rd0Ready;
  logic [31:0]          w_rd1Val;
  logic                 w_rd1Ready;

  // Writes and allocs aimed at preg 0 are dropped so it stays a constant zero.
  assign w_wbHit    = i_ex_valid    && (i_ex_dst_index != '0);
  assign w_allocHit = i_alloc_valid && (i_alloc_index  != '0);

  // Next ready vector: writeback sets, alloc clears (alloc wins), flush sets all.
  always_comb begin
    w_readyNext = r_ready;
    if (w_wbHit)    w_readyNext[i_ex_dst_index] = 1'b1;
    if (w_allocHit) w_readyNext[i_alloc_index]  = 1'b0;
    if (i_flush)    w_readyNext = '1;
    w_readyNext[0] = 1'b1;
  end

  // Read data selection: stored state, or the in-flight writeback when bypass is built in.
  always_comb begin
    w_rd0Val   = r_regs[i_rd0_index];
    w_rd0Ready = r_ready[i_rd0_index];
    w_rd1Val   = r_regs[i_rd1_index];
    w_rd1Ready = r_ready[i_rd1_index];
`ifdef WB_BYPASS_EN
    if (w_wbHit && (i_rd0_index == i_ex_dst_index)) begin
      w_rd0Val   = i_ex_dst_val;
      w_rd0Ready = w_readyNext[i_rd0_index];
    end
    if (w_wbHit && (i_rd1_index == i_ex_dst_index)) begin
      w_rd1Val   = i_ex_dst_val;
      w_rd1Ready = w_readyNext[i_rd1_index];
    end
`endif
  end

  // Register array and scoreboard update; reset clears values and marks all ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_ready <= '1;
    end else begin
      if (w_wbHit) r_regs[i_ex_dst_index] <= i_ex_dst_val;
      r_ready <= w_readyNext;
    end
  end

  // Registered read ports; outputs hold between read requests.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd0Val   <= '0;
      r_rd0Ready <= 1'b1;
      r_rd1Val   <= '0;
      r_rd1Ready <= 1'b1;
    end else begin
      if (i_rd0_en) begin
        r_rd0Val   <= w_rd0Val;
        r_rd0Ready <= w_rd0Ready;
      end
      if (i_rd1_en) begin
        r_rd1Val   <= w_rd1Val;
        r_rd1Ready <= w_rd1Ready;
      end
    end
  end

  assign o_rd0_val   = r_rd0Val;
  assign o_rd0_ready = r_rd0Ready;
  assign o_rd1_val   = r_rd1Val;
  assign o_rd1_ready = r_rd1Ready;

  logic w_unusedPw;
  assign w_unusedPw = (PW > 0);

endmodule

// File: tb/tb_phys_reg_file.sv
// Self-checking bench for phys_reg_file: table of single-cycle vectors
// with expected read results queued per port and compared one cycle later,
// plus a hand-written reset-during-read sequence.
module tb_phys_reg_file;

  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          exValid;
  logic [31:0]   exDstVal;
  logic [PW-1:0] exDstIndex;
  logic          allocValid;
  logic [PW-1:0] allocIndex;
  logic          flush;
  logic          rd0En;
  logic [PW-1:0] rd0Index;
  logic [31:0]   rd0Val;
  logic          rd0Ready;
  logic          rd1En;
  logic [PW-1:0] rd1Index;
  logic [31:0]   rd1Val;
  logic          rd1Ready;

  typedef struct {
    string         name;
    logic          exV;
    logic [PW-1:0] exIdx;
    logic [31:0]   exVal;
    logic          alV;
    logic [PW-1:0] alIdx;
    logic          fl;
    logic          r0En;
    logic [PW-1:0] r0Idx;
    logic [31:0]   e0Val;
    logic          e0Rdy;
    logic          r1En;
    logic [PW-1:0] r1Idx;
    logic [31:0]   e1Val;
    logic          e1Rdy;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] val;
    logic        rdy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t last0;
  exp_t last1;

  int testsRun = 0;
  int testsFailed = 0;

  vec_t vecs[16];
  vec_t post[3];

  phys_reg_file #(.NUM_PREGS(64)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_ex_valid     (exValid),
    .i_ex_dst_val   (exDstVal),
    .i_ex_dst_index (exDstIndex),
    .i_alloc_valid  (allocValid),
    .i_alloc_index  (allocIndex),
    .i_flush        (flush),
    .i_rd0_en       (rd0En),
    .i_rd0_index    (rd0Index),
    .o_rd0_val      (rd0Val),
    .o_rd0_ready    (rd0Ready),
    .i_rd1_en       (rd1En),
    .i_rd1_index    (rd1Index),
    .o_rd1_val      (rd1Val),
    .o_rd1_ready    (rd1Ready)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm,
                              logic exV, logic [PW-1:0] exIdx, logic [31:0] exVal,
                              logic alV, logic [PW-1:0] alIdx, logic fl,
                              logic r0En, logic [PW-1:0] r0Idx, logic [31:0] e0Val, logic e0Rdy,
                              logic r1En, logic [PW-1:0] r1Idx, logic [31:0] e1Val, logic e1Rdy);
    vec_t v;
    v.name = nm; v.exV = exV; v.exIdx = exIdx; v.exVal = exVal;
    v.alV = alV; v.alIdx = alIdx; v.fl = fl;
    v.r0En = r0En; v.r0Idx = r0Idx; v.e0Val = e0Val; v.e0Rdy = e0Rdy;
    v.r1En = r1En; v.r1Idx = r1Idx; v.e1Val = e1Val; v.e1Rdy = e1Rdy;
    return v;
  endfunction

  task automatic clearInputs();
    exValid = 0; exDstVal = '0; exDstIndex = '0;
    allocValid = 0; allocIndex = '0; flush = 0;
    rd0En = 0; rd0Index = '0; rd1En = 0; rd1Index = '0;
  endtask

  task automatic compareOne(string nm, logic [31:0] gotVal, logic gotRdy, exp_t e);
    testsRun++;
    if (gotVal !== e.val || gotRdy !== e.rdy) begin
      testsFailed++;
      $display("[TB] FAIL %s %s: got val=%h ready=%b, want val=%h ready=%b",
               e.name, nm, gotVal, gotRdy, e.val, e.rdy);
    end
  endtask

  // Drive one vector and queue what each read port should show after the edge.
  task automatic applyStimulus(vec_t v);
    exp_t e;
    exValid = v.exV; exDstIndex = v.exIdx; exDstVal = v.exVal;
    allocValid = v.alV; allocIndex = v.alIdx; flush = v.fl;
    rd0En = v.r0En; rd0Index = v.r0Idx;
    rd1En = v.r1En; rd1Index = v.r1Idx;
    if (v.r0En) begin
      e.name = v.name; e.val = v.e0Val; e.rdy = v.e0Rdy; last0 = e;
    end else begin
      e = last0; e.name = {v.name, "/hold"};
    end
    q0.push_back(e);
    if (v.r1En) begin
      e.name = v.name; e.val = v.e1Val; e.rdy = v.e1Rdy; last1 = e;
    end else begin
      e = last1; e.name = {v.name, "/hold"};
    end
    q1.push_back(e);
  endtask

  // Pop the queued expectations and compare against both read ports.
  task automatic checkOutput();
    exp_t e;
    if (q0.size() == 0 || q1.size() == 0) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL scoreboard: got empty queue, want queued entry");
      return;
    end
    e = q0.pop_front();
    compareOne("port0", rd0Val, rd0Ready, e);
    e = q1.pop_front();
    compareOne("port1", rd1Val, rd1Ready, e);
  endtask

  task automatic runVec(vec_t v);
    applyStimulus(v);
    @(posedge clk); #1;
    checkOutput();
    clearInputs();
  endtask

  initial begin
    exp_t e;
    clearInputs();

    vecs[0]  = mk("readP5P0",     0,0,0,           0,0,0, 1,5,0,1,            1,0,0,1);
    vecs[1]  = mk("allocP7",      0,0,0,           1,7,0, 0,0,0,0,            0,0,0,0);
    vecs[2]  = mk("readP7Busy",   0,0,0,           0,0,0, 1,7,0,0,            1,7,0,0);
`ifdef WB_BYPASS_EN
    vecs[3]  = mk("wbP7ReadSame", 1,7,32'hDEADBEEF,0,0,0, 0,0,0,0,            1,7,32'hDEADBEEF,1);
`else
    vecs[3]  = mk("wbP7ReadSame", 1,7,32'hDEADBEEF,0,0,0, 0,0,0,0,            1,7,0,0);
`endif
    vecs[4]  = mk("readP7Done",   0,0,0,           0,0,0, 1,7,32'hDEADBEEF,1, 0,0,0,0);
    vecs[5]  = mk("wbAllocP0",    1,0,32'h1234,    1,0,0, 0,0,0,0,            0,0,0,0);
    vecs[6]  = mk("readP0",       0,0,0,           0,0,0, 1,0,0,1,            1,0,0,1);
`ifdef WB_BYPASS_EN
    vecs[7]  = mk("wbP9ReadSame", 1,9,32'hA5A5,    0,0,0, 1,9,32'hA5A5,1,     0,0,0,0);
`else
    vecs[7]  = mk("wbP9ReadSame", 1,9,32'hA5A5,    0,0,0, 1,9,0,1,            0,0,0,0);
`endif
    vecs[8]  = mk("readP9",       0,0,0,           0,0,0, 0,0,0,0,            1,9,32'hA5A5,1);
`ifdef WB_BYPASS_EN
    vecs[9]  = mk("wbAllocP3",    1,3,32'h55,      1,3,0, 1,3,32'h55,0,       0,0,0,0);
`else
    vecs[9]  = mk("wbAllocP3",    1,3,32'h55,      1,3,0, 1,3,0,1,            0,0,0,0);
`endif
    vecs[10] = mk("readP3Busy",   0,0,0,           0,0,0, 1,3,32'h55,0,       1,3,32'h55,0);
    vecs[11] = mk("allocP4Flush", 0,0,0,           1,4,1, 0,0,0,0,            1,4,0,1);
    vecs[12] = mk("readAfterFl",  0,0,0,           0,0,0, 1,3,32'h55,1,       1,4,0,1);
    vecs[13] = mk("allocP4",      0,0,0,           1,4,0, 0,0,0,0,            0,0,0,0);
    vecs[14] = mk("readP4Busy",   0,0,0,           0,0,0, 1,4,0,0,            1,9,32'hA5A5,1);
    vecs[15] = mk("bothSameP7",   0,0,0,           0,0,0, 1,7,32'hDEADBEEF,1, 1,7,32'hDEADBEEF,1);

    post[0]  = mk("postRstP7P3",  0,0,0,           0,0,0, 1,7,0,1,            1,3,0,1);
    post[1]  = mk("postRstP4P9",  0,0,0,           0,0,0, 1,4,0,1,            1,9,0,1);
    post[2]  = mk("postRstWbP5",  1,5,32'h77,      0,0,0, 0,0,0,0,            0,0,0,1);

    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    e.name = "reset"; e.val = '0; e.rdy = 1'b1;
    last0 = e; last1 = e;
    compareOne("port0", rd0Val, rd0Ready, e);
    compareOne("port1", rd1Val, rd1Ready, e);

    for (int i = 0; i < 16; i++) runVec(vecs[i]);

    // Reset while a read is in flight: outputs and array must clear.
    q0.delete(); q1.delete();
    rst = 1;
    rd0En = 1; rd0Index = 7;
    rd1En = 1; rd1Index = 3;
    e.name = "rstDuringRead"; e.val = '0; e.rdy = 1'b1;
    q0.push_back(e); q1.push_back(e);
    last0 = e; last1 = e;
    @(posedge clk); #1;
    checkOutput();
    rst = 0;
    clearInputs();

    for (int i = 0; i < 3; i++) runVec(post[i]);
    runVec(mk("readP5", 0,0,0, 0,0,0, 1,5,32'h77,1, 0,0,0,0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
